// File: rtl/core_quant_packer.sv
// Packs a stream of signed INT8 quant results into PACK_NUM-lane words with a byte strobe
// and buffers the words in a first-word fall-through FIFO for the activation-buffer write port.
// Latency: a word pushed on cycle N is presented at odata with odata_valid=1 on cycle N+1.
// Backpressure: the input is never stalled. If the FIFO is full with no pop, the word is dropped
// and the sticky overflow flag is set.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   idata/idata_valid incoming element, always accepted
//   flush             emit any partial word now (single-cycle pulse)
//   clr_overflow      clears the sticky overflow flag
//   odata/odata_strb  head packed word and lane mask, lane 0 in the LSBs
//   odata_valid/ready head-word handshake
//   fifo_count        number of occupied FIFO entries
//   overflow          sticky flag: a packed word was dropped
module core_quant_packer #(
  parameter int IDATA_BIT  = 8,
  parameter int PACK_NUM   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IDATA_BIT-1:0]            idata,
  input  logic                            idata_valid,
  input  logic                            flush,
  input  logic                            clr_overflow,
  output logic [IDATA_BIT*PACK_NUM-1:0]   odata,
  output logic [PACK_NUM-1:0]             odata_strb,
  output logic                            odata_valid,
  input  logic                            odata_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow
);

  localparam int WW = IDATA_BIT * PACK_NUM;
  localparam int CW = $clog2(PACK_NUM);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  // Assembly state
  logic [CW-1:0]       cnt;
  logic [WW-1:0]       asm_data;
  logic [PACK_NUM-1:0] asm_strb;

  // Word as it would look with the current element merged in
  logic [WW-1:0]       word_nxt;
  logic [PACK_NUM-1:0] strb_nxt;
  logic                last_lane;
  logic                push;

  always_comb begin
    word_nxt = asm_data;
    strb_nxt = asm_strb;
    if (idata_valid) begin
      for (int i = 0; i < PACK_NUM; i++) begin
        if (cnt == CW'(i)) begin
          word_nxt[i*IDATA_BIT +: IDATA_BIT] = idata;
          strb_nxt[i]                        = 1'b1;
        end
      end
    end
  end

  assign last_lane = (cnt == CW'(PACK_NUM - 1));

  // A flush pushes only if there is something to send, counting a byte arriving
  // in the same cycle. A full word and a flush together still push once.
  assign push = (idata_valid && last_lane) ||
                (flush && (idata_valid || (cnt != '0)));

  // Clearing the assembly register after every push keeps the unwritten lanes of
  // the next partial word at zero without extra masking.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      asm_data <= '0;
      asm_strb <= '0;
    end else if (push) begin
      cnt      <= '0;
      asm_data <= '0;
      asm_strb <= '0;
    end else if (idata_valid) begin
      cnt      <= cnt + 1'b1;
      asm_data <= word_nxt;
      asm_strb <= strb_nxt;
    end
  end

  // Packed-word FIFO
  logic [WW-1:0]       mem_data [FIFO_DEPTH];
  logic [PACK_NUM-1:0] mem_strb [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [NW-1:0]       count;
  logic                pop;
  logic                full;
  logic                wr_en;
  logic                drop;

  assign odata_valid = (count != '0);
  assign pop         = odata_valid && odata_ready;
  assign full        = (count == NW'(FIFO_DEPTH));
  // When full, a same-cycle pop frees the head slot, which is exactly where
  // wr_ptr points, so the write is safe.
  assign wr_en       = push && (!full || pop);
  assign drop        = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= word_nxt;
      mem_strb[wr_ptr] <= strb_nxt;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  // Gating by odata_valid keeps stale storage off the outputs after reset and
  // when the FIFO is empty.
  assign odata      = odata_valid ? mem_data[rd_ptr] : '0;
  assign odata_strb = odata_valid ? mem_strb[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_core_quant_packer.sv
module tb_core_quant_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  idata;
  logic        idata_valid;
  logic        flush;
  logic        clr_overflow;
  logic [31:0] odata;
  logic [3:0]  odata_strb;
  logic        odata_valid;
  logic        odata_ready;
  logic [2:0]  fifo_count;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  core_quant_packer #(.IDATA_BIT(8), .PACK_NUM(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .idata(idata), .idata_valid(idata_valid),
    .flush(flush), .clr_overflow(clr_overflow), .odata(odata),
    .odata_strb(odata_strb), .odata_valid(odata_valid),
    .odata_ready(odata_ready), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one element for a single cycle, optionally with flush.
  task automatic send(input logic [7:0] b, input logic fl);
    idata       = b;
    idata_valid = 1'b1;
    flush       = fl;
    step();
    idata_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idata = '0; idata_valid = 1'b0; flush = 1'b0;
    clr_overflow = 1'b0; odata_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++; if (odata_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", odata_valid); end
    checks++; if (odata !== 32'h0) begin failures++; $display("FAIL reset_odata got=%h exp=0", odata); end
    checks++; if (odata_strb !== 4'h0) begin failures++; $display("FAIL reset_strb got=%b exp=0000", odata_strb); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_basic();
    odata_ready = 1'b1;
    send(8'h01, 1'b0);
    checks++; if (odata_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", odata_valid); end
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h80, 1'b0);
    checks++; if (odata_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", odata_valid); end
    checks++; if (odata !== 32'h80030201) begin failures++; $display("FAIL basic_odata got=%h exp=80030201", odata); end
    checks++; if (odata_strb !== 4'b1111) begin failures++; $display("FAIL basic_strb got=%b exp=1111", odata_strb); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", fifo_count); end
    step();
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL basic_count_pop got=%0d exp=0", fifo_count); end
    odata_ready = 1'b0;
  endtask

  task automatic test_partial_flush();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (odata !== 32'h0000BBAA) begin failures++; $display("FAIL pflush_odata got=%h exp=0000bbaa", odata); end
    checks++; if (odata_strb !== 4'b0011) begin failures++; $display("FAIL pflush_strb got=%b exp=0011", odata_strb); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL pflush_count got=%0d exp=1", fifo_count); end
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL empty_flush_count got=%0d exp=1", fifo_count); end
    odata_ready = 1'b1; step(); odata_ready = 1'b0;
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL pflush_drain got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_flush_same_cycle();
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    checks++; if (odata !== 32'h00002211) begin failures++; $display("FAIL sflush_odata got=%h exp=00002211", odata); end
    checks++; if (odata_strb !== 4'b0011) begin failures++; $display("FAIL sflush_strb got=%b exp=0011", odata_strb); end
    step();
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL sflush_one_word got=%0d exp=1", fifo_count); end
    // Flush together with a byte at lane 0 sends a one-lane word.
    send(8'h9C, 1'b1);
    checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL lane0_flush_count got=%0d exp=2", fifo_count); end
    odata_ready = 1'b1; step();
    checks++; if (odata !== 32'h0000009C) begin failures++; $display("FAIL lane0_flush_odata got=%h exp=0000009c", odata); end
    checks++; if (odata_strb !== 4'b0001) begin failures++; $display("FAIL lane0_flush_strb got=%b exp=0001", odata_strb); end
    step(); odata_ready = 1'b0;
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL sflush_drain got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    odata_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(8'h10 + 8'(i), 1'b0);
      if (i == 15) begin
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_full_count got=%0d exp=4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
    end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_sat_count got=%0d exp=4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    // Another dropped word with clr_overflow on the same cycle: set wins.
    send(8'h60, 1'b0); send(8'h61, 1'b0); send(8'h62, 1'b0);
    clr_overflow = 1'b1; send(8'h63, 1'b0); clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    odata_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = {8'h13 + 8'(4*k), 8'h12 + 8'(4*k), 8'h11 + 8'(4*k), 8'h10 + 8'(4*k)};
      checks++; if (odata !== exp || odata_strb !== 4'b1111) begin failures++; $display("FAIL ovf_word%0d got=%h/%b exp=%h/1111", k, odata, odata_strb, exp); end
      step();
    end
    odata_ready = 1'b0;
    checks++; if (fifo_count !== 3'd0 || odata_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained count=%0d valid=%b exp=0/0", fifo_count, odata_valid); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_with_pop();
    logic [31:0] exp;
    odata_ready = 1'b0;
    for (int i = 0; i < 19; i++) send(8'h40 + 8'(i), 1'b0);
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fpop_prefill got=%0d exp=4", fifo_count); end
    odata_ready = 1'b1;
    send(8'h53, 1'b0);
    odata_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpop_overflow got=%b exp=0", overflow); end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fpop_count got=%0d exp=4", fifo_count); end
    odata_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      exp = {8'h43 + 8'(4*k), 8'h42 + 8'(4*k), 8'h41 + 8'(4*k), 8'h40 + 8'(4*k)};
      checks++; if (odata !== exp) begin failures++; $display("FAIL fpop_word%0d got=%h exp=%h", k, odata, exp); end
      step();
    end
    odata_ready = 1'b0;
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL fpop_drained got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_reset_mid_word();
    send(8'hE1, 1'b0); send(8'hE2, 1'b0); send(8'hE3, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (fifo_count !== 3'd0 || odata_valid !== 1'b0) begin failures++; $display("FAIL rmid_after_rst count=%0d valid=%b exp=0/0", fifo_count, odata_valid); end
    send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h07, 1'b0); send(8'h08, 1'b0);
    checks++; if (odata !== 32'h08070605) begin failures++; $display("FAIL rmid_odata got=%h exp=08070605", odata); end
    checks++; if (odata_strb !== 4'b1111) begin failures++; $display("FAIL rmid_strb got=%b exp=1111", odata_strb); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL rmid_count got=%0d exp=1", fifo_count); end
    odata_ready = 1'b1; step(); odata_ready = 1'b0;
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rmid_pop got=%0d exp=0", fifo_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_flush();
    test_flush_same_cycle();
    test_overflow();
    test_full_with_pop();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
